// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and default widths for the data RAM arbiter
package dmem_pkg;
   localparam int DEF_ADDR_W = 14;
   localparam int DEF_DATA_W = 32;
   typedef enum logic [1:0] {RUN, DRAIN, PROG} state_t;
   typedef enum logic {OWN_CPU, OWN_DBG} owner_t;
endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: 2-way round-robin arbiter, bit 0 = CPU, bit 1 = DBG
module rr_arb2
   import dmem_pkg::*;
(
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_en,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt
);
   owner_t r_last;
   assign o_gnt = !i_en ? 2'b00 : (&i_req) ? ((r_last == OWN_DBG) ? 2'b01 : 2'b10) : i_req;
   always_ff @(posedge i_clock or posedge i_reset)
      if (i_reset) r_last <= OWN_DBG;
      else if (|o_gnt) r_last <= o_gnt[1] ? OWN_DBG : OWN_CPU;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: data RAM access controller for CPU, debug port and UART programmer
// Sequences RUN/DRAIN/PROG hand-over and tags each read return with its owner.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [31:0]       cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] rdata,
   input  logic              upg_rst_i,
   input  logic              upg_done_i,
   input  logic              upg_wen_i,
   input  logic [13:0]       upg_adr_i,
   input  logic [31:0]       upg_dat_i,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              prog_mode
);
   state_t r_state, w_next;
   owner_t r_rd_owner;
   logic r_rd_pend;
   logic [ADDR_W-1:0] r_addr, w_cpu_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [1:0] w_gnt;
   logic w_prog_req, w_arb_en, w_rd_gnt, w_unused;
   assign w_prog_req = ~upg_rst_i & ~upg_done_i;
   assign w_arb_en = (r_state == RUN) & ~reset;
   assign w_cpu_addr = cpu_addr[ADDR_W+1:2];
   assign w_unused = &{1'b0, cpu_addr[31:ADDR_W+2], cpu_addr[1:0]};
   rr_arb2 u_arb (
      .i_clock (clock),
      .i_reset (reset),
      .i_en    (w_arb_en),
      .i_req   ({dbg_req, cpu_req}),
      .o_gnt   (w_gnt)
   );
   always_ff @(posedge clock or posedge reset)
      if (reset) r_state <= RUN;
      else r_state <= w_next;
   // DRAIN lingers only while the last RUN-cycle read is still returning
   always_comb begin
      w_next = (r_state == RUN)   ? (w_prog_req ? DRAIN : RUN) :
               (r_state == DRAIN) ? (!w_prog_req ? RUN : r_rd_pend ? DRAIN : PROG) :
                                    (w_prog_req ? PROG : RUN);
   end
   always_comb begin
      prog_mode = (r_state == PROG);
      cpu_gnt   = w_gnt[0];
      dbg_gnt   = w_gnt[1];
      cpu_stall = cpu_req & ~w_gnt[0];
      ram_we    = w_gnt[0] ? cpu_we : w_gnt[1] ? dbg_we : prog_mode & upg_wen_i;
      ram_addr  = w_gnt[0] ? w_cpu_addr : w_gnt[1] ? dbg_addr : prog_mode ? ADDR_W'(upg_adr_i) : r_addr;
      ram_wdata = w_gnt[0] ? cpu_wdata : w_gnt[1] ? dbg_wdata : prog_mode ? DATA_W'(upg_dat_i) : r_wdata;
   end
   assign w_rd_gnt = (w_gnt[0] & ~cpu_we) | (w_gnt[1] & ~dbg_we);
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rd_pend  <= 1'b0;
         r_rd_owner <= OWN_CPU;
      end else begin
         r_addr     <= ram_addr;
         r_wdata    <= ram_wdata;
         r_rd_pend  <= w_rd_gnt;
         r_rd_owner <= w_gnt[1] ? OWN_DBG : OWN_CPU;
      end
   assign cpu_rvalid = r_rd_pend & (r_rd_owner == OWN_CPU);
   assign dbg_rvalid = r_rd_pend & (r_rd_owner == OWN_DBG);
   assign rdata = ram_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors against dmem_arbiter with a 1-cycle RAM model
module tb_dmem_arbiter;
   logic clk = 1'b0, reset = 1'b1;
   logic cpu_req = 1'b0, cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0;
   logic dbg_req = 1'b0, dbg_we = 1'b0;
   logic [13:0] dbg_addr = '0;
   logic [31:0] dbg_wdata = '0;
   logic upg_rst_i = 1'b1, upg_done_i = 1'b0, upg_wen_i = 1'b0;
   logic [13:0] upg_adr_i = '0;
   logic [31:0] upg_dat_i = '0;
   logic cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, ram_we, prog_mode;
   logic [31:0] rdata, ram_wdata, ram_rdata;
   logic [13:0] ram_addr;
   logic [31:0] mem [0:16383];
   int n_vec = 0, n_err = 0;
   dmem_arbiter dut (
      .clock(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .rdata(rdata),
      .upg_rst_i(upg_rst_i), .upg_done_i(upg_done_i), .upg_wen_i(upg_wen_i),
      .upg_adr_i(upg_adr_i), .upg_dat_i(upg_dat_i),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .prog_mode(prog_mode)
   );
   always #5 clk = ~clk;
   always_ff @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic settle;
      @(negedge clk);
   endtask
   initial begin
      cpu_req = 1'b1;
      settle;
      check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
      check("rst_cpu_stall", 32'(cpu_stall), 32'd1);
      check("rst_ram_we", 32'(ram_we), 32'd0);
      check("rst_ram_addr", 32'(ram_addr), 32'd0);
      check("rst_prog_mode", 32'(prog_mode), 32'd0);
      check("rst_rvalid", 32'({cpu_rvalid, dbg_rvalid}), 32'd0);
      tick;
      reset = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0010; cpu_wdata = 32'hDEADBEEF;
      settle;
      check("st_gnt", 32'(cpu_gnt), 32'd1);
      check("st_addr", 32'(ram_addr), 32'd4);
      check("st_we", 32'(ram_we), 32'd1);
      check("st_wdata", ram_wdata, 32'hDEADBEEF);
      tick;
      cpu_we = 1'b0;
      settle;
      check("ld_gnt", 32'(cpu_gnt), 32'd1);
      check("ld_addr", 32'(ram_addr), 32'd4);
      check("st_no_rvalid", 32'(cpu_rvalid), 32'd0);
      tick;
      cpu_req = 1'b0;
      settle;
      check("ld_rvalid", 32'(cpu_rvalid), 32'd1);
      check("ld_rdata", rdata, 32'hDEADBEEF);
      check("ld_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
      check("idle_addr_hold", 32'(ram_addr), 32'd4);
      tick;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 14'd8; dbg_wdata = 32'hCAFEF00D;
      settle;
      check("dbg_st_gnt", 32'(dbg_gnt), 32'd1);
      check("dbg_st_addr", 32'(ram_addr), 32'd8);
      check("dbg_st_we", 32'(ram_we), 32'd1);
      tick;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0010;
      dbg_we = 1'b0;
      for (int k = 0; k < 7; k++) begin
         if (k == 6) begin
            cpu_req = 1'b0;
            dbg_req = 1'b0;
         end
         settle;
         if (k < 6) begin
            check("rr_cpu_gnt", 32'(cpu_gnt), 32'(k % 2 == 0));
            check("rr_dbg_gnt", 32'(dbg_gnt), 32'(k % 2 == 1));
            check("rr_stall", 32'(cpu_stall), 32'(k % 2 == 1));
         end
         if (k > 0) begin
            check("rr_cpu_rvalid", 32'(cpu_rvalid), 32'((k - 1) % 2 == 0));
            check("rr_dbg_rvalid", 32'(dbg_rvalid), 32'((k - 1) % 2 == 1));
            check("rr_rdata", rdata, ((k - 1) % 2 == 0) ? 32'hDEADBEEF : 32'hCAFEF00D);
         end
         tick;
      end
      cpu_req = 1'b1;
      settle;
      check("pre_drain_gnt", 32'(cpu_gnt), 32'd1);
      tick;
      cpu_req = 1'b0; upg_rst_i = 1'b0;
      settle;
      check("drain_rvalid", 32'(cpu_rvalid), 32'd1);
      check("drain_rdata", rdata, 32'hDEADBEEF);
      check("drain_prog0", 32'(prog_mode), 32'd0);
      tick;
      cpu_req = 1'b1; dbg_req = 1'b1;
      settle;
      check("drain_no_gnt", 32'({cpu_gnt, dbg_gnt}), 32'd0);
      check("drain_stall", 32'(cpu_stall), 32'd1);
      check("drain_prog1", 32'(prog_mode), 32'd0);
      tick;
      settle;
      check("prog_mode", 32'(prog_mode), 32'd1);
      check("prog_no_gnt", 32'({cpu_gnt, dbg_gnt}), 32'd0);
      tick;
      cpu_req = 1'b0; dbg_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         upg_wen_i = 1'b1; upg_adr_i = 14'(i); upg_dat_i = 32'(i + 1);
         settle;
         check("upg_we", 32'(ram_we), 32'd1);
         check("upg_addr", 32'(ram_addr), 32'(i));
         check("upg_wdata", ram_wdata, 32'(i + 1));
         tick;
      end
      upg_wen_i = 1'b0; upg_done_i = 1'b1;
      settle;
      check("done_prog", 32'(prog_mode), 32'd1);
      check("done_we", 32'(ram_we), 32'd0);
      tick;
      for (int i = 0; i < 5; i++) begin
         cpu_req = (i < 4); cpu_we = 1'b0; cpu_addr = 32'(4 * i);
         settle;
         if (i == 0) check("run_again", 32'(prog_mode), 32'd0);
         if (i < 4) check("upg_ld_gnt", 32'(cpu_gnt), 32'd1);
         if (i > 0) begin
            check("upg_ld_rvalid", 32'(cpu_rvalid), 32'd1);
            check("upg_ld_rdata", rdata, 32'(i));
         end
         tick;
      end
      upg_rst_i = 1'b1; upg_done_i = 1'b0;
      cpu_req = 1'b1; cpu_addr = 32'h0010;
      settle;
      check("pre_rst_gnt", 32'(cpu_gnt), 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      settle;
      check("mid_rst_rvalid", 32'({cpu_rvalid, dbg_rvalid}), 32'd0);
      check("mid_rst_gnt", 32'(cpu_gnt), 32'd0);
      check("mid_rst_stall", 32'(cpu_stall), 32'd1);
      check("mid_rst_addr", 32'(ram_addr), 32'd0);
      check("mid_rst_wdata", ram_wdata, 32'd0);
      check("mid_rst_we", 32'(ram_we), 32'd0);
      check("mid_rst_prog", 32'(prog_mode), 32'd0);
      tick;
      reset = 1'b0; dbg_req = 1'b1; dbg_we = 1'b0;
      settle;
      check("post_rst_rvalid", 32'(cpu_rvalid), 32'd0);
      check("post_rst_cpu_wins", 32'(cpu_gnt), 32'd1);
      check("post_rst_dbg_loses", 32'(dbg_gnt), 32'd0);
      tick;
      settle;
      check("post_rst_dbg_next", 32'(dbg_gnt), 32'd1);
      check("post_rst_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
      tick;
      cpu_req = 1'b0; dbg_req = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
